// File: rtl/fetch_pkg.sv
// Shared fetch-side types and constants.
//   if_id_t          : one fetched instruction {pc, pc_plus4, instr}
//   FQ_DEPTH_DEFAULT : default if_id_queue depth
//   FQ_AF_DEFAULT    : default if_id_queue almost-full threshold
package fetch_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] instr;
  } if_id_t;

  localparam int FQ_DEPTH_DEFAULT = 4;
  localparam int FQ_AF_DEFAULT    = 3;

endpackage

// File: rtl/if_id_queue.sv
// Decoupling queue between fetch and decode, replacing the IF/ID register.
// Fetch keeps enqueuing while decode stalls; a taken branch flushes all
// buffered entries; occupancy and almost-full let fetch throttle.
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   enq_valid/ready/data : fetch side (enq_ready = !full)
//   deq_valid/ready/data : decode side, first-word fall-through,
//                          deq_data is all-zero when !deq_valid
//   flush                : taken branch; discards every entry
//   count, almost_full   : occupancy and count >= AF_THRESH
//   overflow_err         : sticky, enqueue attempted while full
module if_id_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH     = FQ_DEPTH_DEFAULT,
  parameter int AF_THRESH = FQ_AF_DEFAULT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enq_valid,
  output logic                       enq_ready,
  input  if_id_t                     enq_data,
  output logic                       deq_valid,
  input  logic                       deq_ready,
  output if_id_t                     deq_data,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       almost_full,
  output logic                       overflow_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [CW-1:0] count_q;
  logic          ovf_q;
  if_id_t        mem [DEPTH];

  logic full;
  logic empty;
  logic enq_fire;
  logic deq_fire;

  assign full  = (wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}};
  assign empty = (wr_ptr == rd_ptr);

  assign enq_ready = ~full;
  // Flush masks the head immediately so decode never sees a killed entry.
  assign deq_valid = ~empty & ~flush;
  assign deq_data  = deq_valid ? mem[rd_ptr[AW-1:0]] : '0;

  assign enq_fire = enq_valid & ~full & ~flush;
  assign deq_fire = deq_valid & deq_ready;

  assign count        = count_q;
  assign almost_full  = count_q >= CW'(AF_THRESH);
  assign overflow_err = ovf_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else if (flush) begin
      rd_ptr  <= wr_ptr;
      count_q <= '0;
    end else begin
      if (enq_fire) wr_ptr <= wr_ptr + 1'b1;
      if (deq_fire) rd_ptr <= rd_ptr + 1'b1;
      unique case ({enq_fire, deq_fire})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (enq_valid & full) ovf_q <= 1'b1;
    end
  end

  // Storage is never reset: entry validity comes from the pointers alone.
  always_ff @(posedge clk) begin
    if (enq_fire) mem[wr_ptr[AW-1:0]] <= enq_data;
  end

endmodule

// File: tb/tb_if_id_queue.sv
module tb_if_id_queue;
  import fetch_pkg::*;

  localparam int DEPTH = 4;
  localparam int AFT   = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       enq_valid;
  logic       enq_ready;
  if_id_t     enq_data;
  logic       deq_valid;
  logic       deq_ready;
  if_id_t     deq_data;
  logic       flush;
  logic [2:0] count;
  logic       almost_full;
  logic       overflow_err;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: plain queue of entries plus the sticky error flag.
  if_id_t q[$];
  logic   m_ov;

  typedef struct packed {
    logic       dv;
    if_id_t     dd;
    logic [2:0] cnt;
    logic       er;
    logic       af;
    logic       ov;
  } obs_t;

  obs_t act;
  assign act = '{dv: deq_valid, dd: deq_data, cnt: count, er: enq_ready,
                 af: almost_full, ov: overflow_err};

  if_id_queue #(.DEPTH(DEPTH), .AF_THRESH(AFT)) dut (
    .clk(clk), .reset(reset), .enq_valid(enq_valid), .enq_ready(enq_ready),
    .enq_data(enq_data), .deq_valid(deq_valid), .deq_ready(deq_ready),
    .deq_data(deq_data), .flush(flush), .count(count),
    .almost_full(almost_full), .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  function automatic if_id_t mk(input logic [31:0] pc);
    if_id_t e;
    e.pc       = pc;
    e.pc_plus4 = pc + 32'd4;
    e.instr    = $urandom;
    return e;
  endfunction

  function automatic obs_t exp_obs();
    obs_t o;
    o.dv  = (q.size() > 0) && !flush;
    o.dd  = o.dv ? q[0] : '0;
    o.cnt = 3'(q.size());
    o.er  = q.size() < DEPTH;
    o.af  = q.size() >= AFT;
    o.ov  = m_ov;
    return o;
  endfunction

  task automatic drive(input logic ev, input logic [31:0] pc, input logic dr, input logic fl);
    enq_valid = ev;
    enq_data  = mk(pc);
    deq_ready = dr;
    flush     = fl;
    #1;
  endtask

  // Advance one clock, applying the queue rules to the model at the edge.
  task automatic tick();
    bit     clr, do_enq, do_deq, set_ov;
    if_id_t e;
    clr    = reset || flush;
    do_enq = !clr && enq_valid && (q.size() < DEPTH);
    do_deq = !clr && deq_ready && (q.size() > 0);
    set_ov = !clr && enq_valid && (q.size() == DEPTH);
    e      = enq_data;
    @(posedge clk);
    if (clr) q.delete();
    if (reset) m_ov = 1'b0;
    if (do_deq) void'(q.pop_front());
    if (do_enq) q.push_back(e);
    if (set_ov) m_ov = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b1, 32'h0, 1'b0, 1'b0);
    tick();
    tick();
    n_tests++;
    if (act !== exp_obs()) begin
      n_fail++;
      $display("FAIL reset_state act=%h exp=%h", act, exp_obs());
    end
    n_tests++;
    if ({deq_valid, count, enq_ready, overflow_err, deq_data} !== {1'b0, 3'd0, 1'b1, 1'b0, 96'd0}) begin
      n_fail++;
      $display("FAIL reset_literal dv=%b cnt=%0d er=%b ov=%b", deq_valid, count, enq_ready, overflow_err);
    end
    reset = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'(i * 4), 1'b0, 1'b0);
      tick();
      n_tests++;
      if (act !== exp_obs() || count !== 3'(i + 1) || almost_full !== (i >= 2)) begin
        n_fail++;
        $display("FAIL fill_%0d act=%h exp=%h", i, act, exp_obs());
      end
    end
    n_tests++;
    if (enq_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL full_enq_ready act=%b exp=0", enq_ready);
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      n_tests++;
      if (act !== exp_obs() || deq_valid !== 1'b1 || deq_data.pc !== 32'(i * 4)) begin
        n_fail++;
        $display("FAIL drain_%0d pc=%h exp=%h act=%h", i, deq_data.pc, i * 4, act);
      end
      tick();
    end
    n_tests++;
    if (deq_valid !== 1'b0 || act !== exp_obs()) begin
      n_fail++;
      $display("FAIL drained_empty act=%h exp=%h", act, exp_obs());
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h20 + 32'(i * 4), 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 32'h40, 1'b1, 1'b1);
    n_tests++;
    if (deq_valid !== 1'b0 || act !== exp_obs()) begin
      n_fail++;
      $display("FAIL flush_cycle dv=%b act=%h exp=%h", deq_valid, act, exp_obs());
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      n_tests++;
      if (count !== 3'd0 || deq_valid !== 1'b0 || act !== exp_obs()) begin
        n_fail++;
        $display("FAIL after_flush_%0d cnt=%0d dv=%b pc=%h", i, count, deq_valid, deq_data.pc);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] nxt_enq, nxt_deq;
    nxt_enq = 32'h200;
    nxt_deq = 32'h200;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, nxt_enq, 1'b0, 1'b0);
      nxt_enq += 4;
      tick();
    end
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, nxt_enq, 1'b1, 1'b0);
      nxt_enq += 4;
      n_tests++;
      if (count !== 3'd2 || deq_data.pc !== nxt_deq || act !== exp_obs()) begin
        n_fail++;
        $display("FAIL b2b_%0d cnt=%0d pc=%h exp_pc=%h", i, count, deq_data.pc, nxt_deq);
      end
      nxt_deq += 4;
      tick();
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    tick();
    tick();
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h300 + 32'(i * 4), 1'b0, 1'b0);
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 32'h80, 1'b0, 1'b0);
      tick();
      n_tests++;
      if (overflow_err !== 1'b1 || count !== 3'd4 || act !== exp_obs()) begin
        n_fail++;
        $display("FAIL overflow_%0d ov=%b cnt=%0d", i, overflow_err, count);
      end
    end
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      n_tests++;
      if (act !== exp_obs() || (i < 4 && deq_data.pc !== 32'h300 + 32'(i * 4)) || overflow_err !== 1'b1) begin
        n_fail++;
        $display("FAIL ovf_drain_%0d pc=%h ov=%b act=%h", i, deq_data.pc, overflow_err, act);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h500 + 32'(i * 4), 1'b0, 1'b0);
      tick();
    end
    reset = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    reset = 1'b0;
    drive(1'b1, 32'h100, 1'b0, 1'b0);
    n_tests++;
    if (count !== 3'd0 || deq_valid !== 1'b0 || overflow_err !== 1'b0 || act !== exp_obs()) begin
      n_fail++;
      $display("FAIL reset_mid cnt=%0d dv=%b ov=%b", count, deq_valid, overflow_err);
    end
    tick();
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    n_tests++;
    if (deq_valid !== 1'b1 || deq_data.pc !== 32'h100 || act !== exp_obs()) begin
      n_fail++;
      $display("FAIL post_reset_enq dv=%b pc=%h exp=00000100", deq_valid, deq_data.pc);
    end
    tick();
  endtask

  task automatic test_random();
    logic [31:0] pc;
    pc = 32'h1000;
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      drive(1'($urandom_range(0, 3) != 0), pc, 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 19) == 0));
      pc += 4;
      n_tests++;
      if (act !== exp_obs()) begin
        n_fail++;
        $display("FAIL random_%0d act=%h exp=%h", i, act, exp_obs());
      end
      tick();
    end
    reset = 1'b0;
  endtask

  initial begin
    m_ov      = 1'b0;
    reset     = 1'b1;
    enq_valid = 1'b1;
    enq_data  = '0;
    deq_ready = 1'b0;
    flush     = 1'b0;
    test_reset();
    test_fill_drain();
    test_flush();
    test_back_to_back();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
